// File: rtl/hammer_pkg.sv
// -----------------------------------------------------------------------------
// hammer_pkg
// Shared definitions for the rowhammer campaign controller:
//   - camp_state_t : campaign sequencer states
//   - ENG_FINISH   : engine state code that marks a completed run
//   - insert_row() : overwrites the row field of an address
// -----------------------------------------------------------------------------
package hammer_pkg;

  localparam int unsigned MAX_ADDR_W = 64;

  localparam logic [3:0] ENG_FINISH = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_CAPTURE,
    ST_REPORT,
    ST_NEXT,
    ST_DONE
  } camp_state_t;

  // Replace addr[pos +: width] with the low bits of row. A width of 64 wraps
  // the shifted one to zero, so the mask still comes out all-ones.
  function automatic logic [MAX_ADDR_W-1:0] insert_row(
    input logic [MAX_ADDR_W-1:0] addr,
    input logic [MAX_ADDR_W-1:0] row,
    input int unsigned           pos,
    input int unsigned           width
  );
    logic [MAX_ADDR_W-1:0] mask;
    mask = ((64'd1 << width) - 64'd1) << pos;
    return (addr & ~mask) | ((row << pos) & mask);
  endfunction

endpackage

// File: rtl/hammer_watchdog.sv
// -----------------------------------------------------------------------------
// hammer_watchdog
// Loadable cycle counter that stops at a terminal value.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_clr            : synchronous clear to zero (highest priority)
//   i_load/i_load_value : synchronous load
//   i_en             : count enable
//   o_term           : counter equals TERMINAL
// -----------------------------------------------------------------------------
module hammer_watchdog #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     TERMINAL = '1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_en,
  output logic             o_term
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             w_term;

  assign w_term = (r_count == TERMINAL);
  assign o_term = w_term;

  // Holding at the terminal value keeps o_term asserted instead of wrapping.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_en && !w_term) begin
      r_count <= r_count + ONE;
    end
  end

endmodule

// File: rtl/hammer_campaign_ctrl.sv
// -----------------------------------------------------------------------------
// hammer_campaign_ctrl
// Walks the rowhammer engine across rows i_row_first..i_row_last, restarting
// it per row, waiting for FINISH (or a watchdog timeout), capturing the flip
// tally, offering each result over a valid/ready handshake and keeping
// campaign totals (saturating sum, maximum and the row that produced it).
//
// Build option: HAMMER_CAMPAIGN_INVERT_EN -- when defined every row runs twice,
// first with the pattern and then with its inverse; both results carry the
// same row.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_start, i_abort          campaign start pulse, abort level
//   i_base_address, i_row_first, i_row_last, i_pattern, i_count  config
//   o_eng_reset, o_eng_address, o_eng_pattern, o_eng_count       engine drive
//   i_eng_state, i_eng_flip_count                                engine status
//   o_res_valid, i_res_ready, o_res_row, o_res_flips, o_res_timeout  results
//   o_busy, o_done, o_cfg_err, o_aborted                         status
//   o_total_flips, o_max_flips, o_max_row                        totals
// -----------------------------------------------------------------------------
import hammer_pkg::*;

module hammer_campaign_ctrl #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 64,
  parameter int unsigned ROW_WIDTH  = 12,
  parameter int unsigned ROW_POS    = 10,
  parameter logic [31:0] TIMEOUT    = 32'd16777215
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_address,
  input  logic [ROW_WIDTH-1:0]  i_row_first,
  input  logic [ROW_WIDTH-1:0]  i_row_last,
  input  logic [WORD_WIDTH-1:0] i_pattern,
  input  logic [31:0]           i_count,
  output logic                  o_eng_reset,
  output logic [ADDR_WIDTH-1:0] o_eng_address,
  output logic [WORD_WIDTH-1:0] o_eng_pattern,
  output logic [31:0]           o_eng_count,
  input  logic [3:0]            i_eng_state,
  input  logic [63:0]           i_eng_flip_count,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [ROW_WIDTH-1:0]  o_res_row,
  output logic [63:0]           o_res_flips,
  output logic                  o_res_timeout,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cfg_err,
  output logic                  o_aborted,
  output logic [63:0]           o_total_flips,
  output logic [63:0]           o_max_flips,
  output logic [ROW_WIDTH-1:0]  o_max_row
);

  localparam logic [ROW_WIDTH-1:0] ROW_ONE = {{(ROW_WIDTH-1){1'b0}}, 1'b1};

  camp_state_t r_state, w_state_next;

  logic                  r_launch_cnt;
  logic                  r_phase;        // 1 = inverted-pattern run of the row
  logic                  r_run_timeout;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ROW_WIDTH-1:0]  r_row_last, r_cur_row, r_res_row, r_max_row;
  logic [WORD_WIDTH-1:0] r_pattern;
  logic [31:0]           r_count;
  logic [63:0]           r_res_flips, r_total, r_max_flips;
  logic                  r_res_timeout, r_cfg_err, r_aborted;

  logic                  w_start_take, w_range_bad, w_abort_now, w_eng_finish;
  logic                  w_wd_term, w_wd_clr, w_wd_en;
  logic [63:0]           w_flips;
  logic [64:0]           w_sum;
  logic [MAX_ADDR_W-1:0] w_addr_full;

  hammer_watchdog #(
    .WIDTH    (32),
    .TERMINAL (TIMEOUT)
  ) u_watchdog (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clr        (w_wd_clr),
    .i_load       (1'b0),
    .i_load_value ('0),
    .i_en         (w_wd_en),
    .o_term       (w_wd_term)
  );

  assign w_eng_finish = (i_eng_state == ENG_FINISH);
  assign w_range_bad  = (i_row_last < i_row_first);
  assign w_start_take = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_abort_now  = i_abort && (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_flips      = r_run_timeout ? 64'd0 : i_eng_flip_count;
  assign w_sum        = {1'b0, r_total} + {1'b0, w_flips};
  assign w_addr_full  = insert_row(MAX_ADDR_W'(r_base), MAX_ADDR_W'(r_cur_row),
                                   ROW_POS, ROW_WIDTH);

  assign o_eng_address = w_addr_full[ADDR_WIDTH-1:0];
  assign o_eng_pattern = r_phase ? ~r_pattern : r_pattern;
  assign o_eng_count   = r_count;
  assign o_res_row     = r_res_row;
  assign o_res_flips   = r_res_flips;
  assign o_res_timeout = r_res_timeout;
  assign o_cfg_err     = r_cfg_err;
  assign o_aborted     = r_aborted;
  assign o_total_flips = r_total;
  assign o_max_flips   = r_max_flips;
  assign o_max_row     = r_max_row;

  always_comb begin
    w_state_next = r_state;
    o_eng_reset  = 1'b1;
    o_res_valid  = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    w_wd_clr     = 1'b1;
    w_wd_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_state_next = w_range_bad ? ST_DONE : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (r_launch_cnt) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        o_eng_reset = 1'b0;
        w_wd_clr    = 1'b0;
        w_wd_en     = 1'b1;
        if (w_eng_finish || w_wd_term) w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        o_eng_reset  = 1'b0;
        w_state_next = ST_REPORT;
      end
      ST_REPORT: begin
        o_eng_reset = 1'b0;
        o_res_valid = 1'b1;
        if (i_res_ready) w_state_next = ST_NEXT;
      end
      ST_NEXT: begin
        o_eng_reset = 1'b0;
`ifdef HAMMER_CAMPAIGN_INVERT_EN
        if (!r_phase) w_state_next = ST_LAUNCH;
        else
`endif
        if (r_cur_row == r_row_last) w_state_next = ST_DONE;
        else                         w_state_next = ST_LAUNCH;
      end
      ST_DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
        if (i_start) w_state_next = w_range_bad ? ST_DONE : ST_LAUNCH;
      end
      default: w_state_next = ST_IDLE;
    endcase
    // A transfer accepted in the same cycle has already happened; abort still
    // wins the next state.
    if (w_abort_now) w_state_next = ST_DONE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_launch_cnt  <= 1'b0;
      r_phase       <= 1'b0;
      r_run_timeout <= 1'b0;
      r_base        <= '0;
      r_row_last    <= '0;
      r_cur_row     <= '0;
      r_pattern     <= '0;
      r_count       <= '0;
      r_res_row     <= '0;
      r_res_flips   <= '0;
      r_res_timeout <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_aborted     <= 1'b0;
      r_total       <= '0;
      r_max_flips   <= '0;
      r_max_row     <= '0;
    end else begin
      r_state      <= w_state_next;
      // Two-cycle LAUNCH: the flag is set on the first cycle only.
      r_launch_cnt <= (r_state == ST_LAUNCH) && !r_launch_cnt;

      if (w_start_take) begin
        r_base        <= i_base_address;
        r_row_last    <= i_row_last;
        r_pattern     <= i_pattern;
        r_count       <= i_count;
        r_cur_row     <= i_row_first;
        r_phase       <= 1'b0;
        r_cfg_err     <= w_range_bad;
        r_aborted     <= 1'b0;
        r_total       <= '0;
        r_max_flips   <= '0;
        r_max_row     <= '0;
        r_res_row     <= '0;
        r_res_flips   <= '0;
        r_res_timeout <= 1'b0;
      end

      if (r_state == ST_LAUNCH) r_run_timeout <= 1'b0;
      // FINISH takes priority over a watchdog expiring in the same cycle.
      if ((r_state == ST_RUN) && w_wd_term && !w_eng_finish) r_run_timeout <= 1'b1;

      if (r_state == ST_CAPTURE) begin
        r_res_row     <= r_cur_row;
        r_res_flips   <= w_flips;
        r_res_timeout <= r_run_timeout;
        r_total       <= w_sum[64] ? '1 : w_sum[63:0];
        // Strict compare: equal tallies keep the earlier row.
        if (w_flips > r_max_flips) begin
          r_max_flips <= w_flips;
          r_max_row   <= r_cur_row;
        end
      end

      if ((r_state == ST_NEXT) && (w_state_next == ST_LAUNCH)) begin
`ifdef HAMMER_CAMPAIGN_INVERT_EN
        if (!r_phase) begin
          r_phase <= 1'b1;
        end else begin
          r_phase   <= 1'b0;
          r_cur_row <= r_cur_row + ROW_ONE;
        end
`else
        r_cur_row <= r_cur_row + ROW_ONE;
`endif
      end

      if (w_abort_now) r_aborted <= 1'b1;
    end
  end

endmodule
